// File: rtl/bch_encode_scheduler.sv
// Round-robin scheduler sharing one BCH(15,5) encoder between N_REQ requesters.
// One transaction in flight; the response is held on rsp_* until rsp_ready.
module bch_encode_scheduler #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [5*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               enc_start,
  output logic [4:0]         enc_data,
  input  logic [15:0]        enc_code,
  input  logic               enc_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_code,
  output logic               rsp_err,
  output logic               busy,
  output logic               timeout_sticky
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [4:0]      msg_q, msg_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [15:0]     code_q, code_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;

  logic            gnt_vld, lo_vld, hi_vld;
  logic [ID_W-1:0] gnt_id, lo_id, hi_id;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_vld = 1'b0;
    lo_id  = '0;
    hi_vld = 1'b0;
    hi_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_vld = 1'b1;
        lo_id  = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    gnt_vld = lo_vld;
    gnt_id  = hi_vld ? hi_id : lo_id;
  end

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    code_d     = code_q;
    err_d      = err_q;
    sticky_d   = sticky_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
              // Gated by rst so the accept pulse also drops asynchronously.
              req_ready[i] = ~rst;
              msg_d        = req_data[5*i +: 5];
            end
          end
          id_d    = gnt_id;
          state_d = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (enc_ready) begin
          code_d  = enc_code;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          code_d   = '0;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      msg_q      <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      code_q     <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      code_q     <= code_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign enc_start      = (state_q == S_START);
  assign enc_data       = msg_q;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_id         = id_q;
  assign rsp_code       = code_q;
  assign rsp_err        = err_q;
  assign busy           = (state_q != S_IDLE);
  assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_bch_encode_scheduler.sv
// Self-checking bench: registered encoder stub plus a queue-free transaction-level reference model.
module tb_bch_encode_scheduler;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [5*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           enc_start;
  logic [4:0]     enc_data;
  logic [15:0]    enc_code = 16'hFFFF;
  logic           enc_ready = 1'b1;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [15:0]    rsp_code;
  logic           rsp_err;
  logic           busy;
  logic           timeout_sticky;

  logic           stub_en = 1'b1;
  logic [4:0]     msgs [N];
  int             errors = 0;
  int             checks = 0;
  int             exp_ptr = 0;

  bch_encode_scheduler #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_start(enc_start), .enc_data(enc_data), .enc_code(enc_code), .enc_ready(enc_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_code(rsp_code),
    .rsp_err(rsp_err), .busy(busy), .timeout_sticky(timeout_sticky)
  );

  always #5 clk = ~clk;

  // Codeword = message polynomial times generator 0x537 over GF(2).
  function automatic logic [15:0] clmul(input logic [4:0] m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      if (m[i]) r = r ^ (16'h0537 << i);
    return r;
  endfunction

  // Registered encoder: ready/code update on the edge after start and hold; never reset.
  always @(posedge clk) begin
    if (enc_start) begin
      enc_ready <= stub_en;
      enc_code  <= stub_en ? clmul(enc_data) : 16'hDEAD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    logic [5*N-1:0] rd;
    rd = '0;
    for (int i = 0; i < N; i++) rd = rd | ((5*N)'(msgs[i]) << (5*i));
    req_data = rd;
  endtask

  // Runs one single-requester transaction with rsp_ready high; returns what was observed.
  task automatic send(input int id, input logic [4:0] msg,
                      output logic [N-1:0] gnt, output int lat,
                      output logic [IW-1:0] id_o, output logic [15:0] code_o,
                      output logic err_o, output logic sticky_o,
                      output int start_mask, output logic [4:0] edata,
                      output logic busy_ok, output logic ok);
    ok = 1'b0; gnt = '0; lat = 0; start_mask = 0; edata = '0;
    id_o = '0; code_o = '0; err_o = 1'b0; sticky_o = 1'b0; busy_ok = 1'b1;
    req_valid = N'(1) << id;
    req_data  = (5*N)'(msg) << (5*id);
    rsp_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gnt = req_ready;
        break;
      end
      tick();
    end
    if (gnt == '0) begin
      req_valid = '0;
      return;
    end
    tick();
    req_valid = '0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (enc_start === 1'b1) begin
        if (c < 31) start_mask = start_mask | (1 << c);
        edata = enc_data;
      end
      if (rsp_valid === 1'b1) begin
        lat = c; id_o = rsp_id; code_o = rsp_code; err_o = rsp_err;
        sticky_o = timeout_sticky; ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    if (ok) exp_ptr = (id + 1) % N;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== '0)         begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (enc_start !== 1'b0)      begin errors++; $display("FAIL rst_enc_start: got %b want 0", enc_start); end
    checks++; if (enc_data !== '0)         begin errors++; $display("FAIL rst_enc_data: got %h want 0", enc_data); end
    checks++; if (rsp_valid !== 1'b0)      begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== '0)           begin errors++; $display("FAIL rst_rsp_id: got %h want 0", rsp_id); end
    checks++; if (rsp_code !== '0)         begin errors++; $display("FAIL rst_rsp_code: got %h want 0", rsp_code); end
    checks++; if (rsp_err !== 1'b0)        begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (timeout_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", timeout_sticky); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
    tick();
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    logic [N-1:0] g; int lat; logic [IW-1:0] id; logic [15:0] code;
    logic err, st, bok, ok; int sm; logic [4:0] ed;
    send(0, 5'b00001, g, lat, id, code, err, st, sm, ed, bok, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no response want one"); end
    checks++; if (g !== 2'b01)        begin errors++; $display("FAIL basic_grant: got %b want 01", g); end
    checks++; if (sm != 2)            begin errors++; $display("FAIL basic_start_cycles: got mask %0h want 2", sm); end
    checks++; if (ed !== 5'b00001)    begin errors++; $display("FAIL basic_enc_data: got %b want 00001", ed); end
    checks++; if (lat != 3)           begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
    checks++; if (code !== 16'h0537)  begin errors++; $display("FAIL basic_code: got %h want 0537", code); end
    checks++; if (id !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_id_err: got %0d/%b want 0/0", id, err); end
    checks++; if (!bok)               begin errors++; $display("FAIL basic_busy: got busy low mid-transaction want high"); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    tick();
  endtask

  task automatic test_codes();
    logic [N-1:0] g; int lat; logic [IW-1:0] id; logic [15:0] code;
    logic err, st, bok, ok; int sm; logic [4:0] ed;
    send(1, 5'b00011, g, lat, id, code, err, st, sm, ed, bok, ok);
    checks++; if (!ok || g !== 2'b10 || code !== 16'h0F59 || id !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL code_00011: got ok=%b g=%b code=%h id=%0d err=%b want 1 10 0f59 1 0", ok, g, code, id, err); end
    send(0, 5'b00000, g, lat, id, code, err, st, sm, ed, bok, ok);
    checks++; if (!ok || g !== 2'b01 || code !== 16'h0000 || id !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL code_00000: got ok=%b g=%b code=%h id=%0d err=%b want 1 01 0000 0 0", ok, g, code, id, err); end
  endtask

  task automatic test_fairness();
    int ngr = 0, last = 0, e = 0, pid = 0, cyc = 0;
    int cnt [N];
    logic [4:0] pdata = '0;
    logic newg, got;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; msgs[i] = 5'($urandom); end
    drive_data();
    req_valid = '1;
    rsp_ready = 1'b1;
    while (ngr < 6 && cyc < 200) begin
      @(negedge clk);
      newg = 1'b0;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_id !== IW'(pid) || rsp_code !== clmul(pdata))
          begin errors++; $display("FAIL fair_rsp: got id=%0d code=%h want %0d %h", rsp_id, rsp_code, pid, clmul(pdata)); end
      end
      if (req_ready != '0) begin
        e = (ngr == 0) ? exp_ptr : (last + 1) % N;
        checks++;
        if (req_ready !== (N'(1) << e)) begin errors++; $display("FAIL fair_order: grant %0d got %b want %b", ngr, req_ready, N'(1) << e); end
        last = e; pid = e; pdata = msgs[e]; cnt[e]++; ngr++; newg = 1'b1;
      end
      tick();
      cyc++;
      if (newg) begin msgs[last] = 5'($urandom); drive_data(); end
    end
    req_valid = '0;
    checks++; if (ngr != 6) begin errors++; $display("FAIL fair_grants: got %0d want 6", ngr); end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (rsp_id !== IW'(pid) || rsp_code !== clmul(pdata))
          begin errors++; $display("FAIL fair_last_rsp: got id=%0d code=%h want %0d %h", rsp_id, rsp_code, pid, clmul(pdata)); end
      end
      tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL fair_drain: got no response want one"); end
    checks++; if (cnt[0] != 3 || cnt[1] != 3) begin errors++; $display("FAIL fair_balance: got %0d/%0d want 3/3", cnt[0], cnt[1]); end
    exp_ptr = (last + 1) % N;
  endtask

  task automatic test_backpressure();
    logic [4:0] m, m2;
    logic got;
    logic [IW-1:0] h_id; logic [15:0] h_code; logic h_err;
    m = 5'($urandom); m2 = 5'($urandom);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_data  = (5*N)'(m);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
      tick();
    end
    req_valid = 2'b10;
    req_data  = (5*N)'(m2) << 5;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1; else tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_rsp: got no response want one"); end
    h_id = rsp_id; h_code = rsp_code; h_err = rsp_err;
    checks++; if (h_id !== 1'b0 || h_code !== clmul(m) || h_err !== 1'b0)
      begin errors++; $display("FAIL bp_value: got id=%0d code=%h err=%b want 0 %h 0", h_id, h_code, h_err, clmul(m)); end
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_code !== h_code || rsp_err !== h_err || req_ready !== '0)
        begin errors++; $display("FAIL bp_hold: cycle %0d got v=%b id=%0d code=%h err=%b rdy=%b want held, rdy 0", k, rsp_valid, rsp_id, rsp_code, rsp_err, req_ready); end
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10)
      begin errors++; $display("FAIL bp_release: got rsp_valid=%b req_ready=%b want 0 10", rsp_valid, req_ready); end
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (rsp_id !== 1'b1 || rsp_code !== clmul(m2))
          begin errors++; $display("FAIL bp_next: got id=%0d code=%h want 1 %h", rsp_id, rsp_code, clmul(m2)); end
      end
      tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_next_done: got no response want one"); end
    exp_ptr = 0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] g; int lat; logic [IW-1:0] id; logic [15:0] code;
    logic err, st, bok, ok; int sm; logic [4:0] ed, m;
    m = 5'($urandom_range(1, 31));
    stub_en = 1'b0;
    send(0, m, g, lat, id, code, err, st, sm, ed, bok, ok);
    checks++; if (!ok || lat != TO + 2) begin errors++; $display("FAIL to_latency: got ok=%b lat=%0d want 1 %0d", ok, lat, TO + 2); end
    checks++; if (err !== 1'b1 || code !== 16'h0000) begin errors++; $display("FAIL to_value: got err=%b code=%h want 1 0000", err, code); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", st); end
    checks++; if (sm != 2 || !bok) begin errors++; $display("FAIL to_start: got mask %0h busy_ok=%b want 2 1", sm, bok); end
    stub_en = 1'b1;
    m = 5'($urandom);
    send(1, m, g, lat, id, code, err, st, sm, ed, bok, ok);
    checks++; if (!ok || lat != 3 || err !== 1'b0 || code !== clmul(m) || id !== 1'b1)
      begin errors++; $display("FAIL to_recover: got ok=%b lat=%0d err=%b code=%h id=%0d want 1 3 0 %h 1", ok, lat, err, code, id, clmul(m)); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL to_sticky_hold: got %b want 1", st); end
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [4:0] m;
    m = 5'($urandom);
    stub_en = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    req_data  = (5*N)'(m) << 5;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_in_wait: got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, enc_start, enc_data, rsp_valid, rsp_id, rsp_code, rsp_err, busy, timeout_sticky} !== '0)
      begin errors++; $display("FAIL rm_async_clear: got rdy=%b st=%b d=%h v=%b id=%0d code=%h err=%b busy=%b sticky=%b want all 0",
        req_ready, enc_start, enc_data, rsp_valid, rsp_id, rsp_code, rsp_err, busy, timeout_sticky); end
    tick();
    tick();
    rst = 1'b0;
    stub_en = 1'b1;
    for (int i = 0; i < N; i++) msgs[i] = 5'($urandom);
    drive_data();
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_first_grant: got rdy=%b v=%b want 01 0", req_ready, rsp_valid); end
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (rsp_id !== 1'b0 || rsp_code !== clmul(msgs[0]) || rsp_err !== 1'b0)
          begin errors++; $display("FAIL rm_after: got id=%0d code=%h err=%b want 0 %h 0", rsp_id, rsp_code, rsp_err, clmul(msgs[0])); end
      end
      tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL rm_after_done: got no response want one"); end
    exp_ptr = 1;
  endtask

  task automatic test_random();
    int ptr = exp_ptr, lat = 0, pid = 0, g = 0, idx = 0, nrsp = 0;
    logic pend = 1'b0, seen = 1'b0, perr = 1'b0, found, gr, pend0, abort = 1'b0;
    logic [4:0] pdata = '0;
    logic [N-1:0] exp_oh, v;
    req_valid = '0;
    for (int cyc = 0; cyc < 1540 && !abort; cyc++) begin
      @(negedge clk);
      pend0 = pend;
      found = 1'b0; g = 0; exp_oh = '0;
      if (!pend0) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (!found && ((int'(req_valid) >> idx) & 1) == 1) begin found = 1'b1; g = idx; end
        end
        if (found) exp_oh = N'(1) << g;
      end
      checks++;
      if (req_ready !== exp_oh) begin errors++; $display("FAIL rand_grant: cycle %0d got %b want %b", cyc, req_ready, exp_oh); end
      if (pend0) begin
        lat++;
        if (rsp_valid === 1'b1) begin
          if (!seen) begin
            checks++;
            if (lat != (perr ? TO + 2 : 3)) begin errors++; $display("FAIL rand_latency: got %0d want %0d", lat, perr ? TO + 2 : 3); end
            seen = 1'b1;
          end
          checks++;
          if (rsp_id !== IW'(pid) || rsp_err !== perr || rsp_code !== (perr ? 16'h0000 : clmul(pdata)))
            begin errors++; $display("FAIL rand_rsp: got id=%0d err=%b code=%h want %0d %b %h", rsp_id, rsp_err, rsp_code, pid, perr, perr ? 16'h0000 : clmul(pdata)); end
          if (rsp_ready) begin ptr = (pid + 1) % N; pend = 1'b0; nrsp++; end
        end else if (seen || lat > TO + 4) begin
          checks++; errors++;
          $display("FAIL rand_missing_rsp: cycle %0d got rsp_valid=0 want 1", cyc);
          abort = 1'b1;
        end
      end else if (rsp_valid === 1'b1) begin
        checks++; errors++;
        $display("FAIL rand_spurious_rsp: cycle %0d got rsp_valid=1 want 0", cyc);
      end
      gr = found;
      if (gr) begin pend = 1'b1; pid = g; pdata = msgs[g]; lat = 0; seen = 1'b0; end
      tick();
      if (cyc < 1500) begin
        v = req_valid;
        for (int i = 0; i < N; i++) begin
          if ((gr && i == g) || ((int'(v) >> i) & 1) == 0) begin
            msgs[i] = 5'($urandom);
            if ($urandom_range(0, 2) == 0) v = v | (N'(1) << i);
            else                           v = v & ~(N'(1) << i);
          end
        end
        req_valid = v;
        drive_data();
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      if (gr) begin
        stub_en = ($urandom_range(0, 4) != 0);
        perr = !stub_en;
      end
    end
    checks++; if (pend) begin errors++; $display("FAIL rand_drain: got pending transaction want none"); end
    checks++; if (nrsp < 50) begin errors++; $display("FAIL rand_count: got %0d responses want at least 50", nrsp); end
    stub_en = 1'b1;
    exp_ptr = ptr;
  endtask

  initial begin
    for (int i = 0; i < N; i++) msgs[i] = '0;
    test_reset();
    test_basic();
    test_codes();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bch_encode_scheduler.md
# bch_encode_scheduler

Shares the single BCH(15,5)-style encoder (`BCH_encoder`, generator 0x537) between `N_REQ` requesters. The block arbitrates round-robin, latches the 5-bit message and pulses `startEncoding`, then waits for `EncoderReady` with a timeout. It returns the 16-bit codeword, tagged with the requester id, over a valid/ready response channel. It sits between the message sources and the encoder instance and is the only driver of the encoder's inputs.

## Interface

**Parameters**
- `N_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default 1: width of requester id. Must satisfy `$clog2(N_REQ)`, minimum 1.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT before aborting, 1..255.

**Ports**
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, N_REQ: per-requester message valid.
- `req_data`, in, 5*N_REQ: messages; requester i uses bits `[5i+4:5i]`.
- `req_ready`, out, N_REQ: one-hot accept pulse.
- `enc_start`, out, 1: to encoder `startEncoding`.
- `enc_data`, out, 5: to encoder `signal_input`.
- `enc_code`, in, 16: from encoder `encoded_signal`.
- `enc_ready`, in, 1: from encoder `EncoderReady`.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response consumer ready.
- `rsp_id`, out, ID_W: index of the requester served.
- `rsp_code`, out, 16: codeword.
- `rsp_err`, out, 1: this response was aborted by timeout.
- `busy`, out, 1: the FSM is not in IDLE.
- `timeout_sticky`, out, 1: a timeout has occurred since reset.

## Operation

- **FSM states:** IDLE, START, WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap at N_REQ.
  - `req_ready[g]` is combinationally high in this cycle only.
  - Latch `req_data[g]` into `msg_q` and `g` into `id_q`, then go to START.
  - If no `req_valid` bit is set, stay in IDLE.
- **START:** `enc_start=1` for exactly one cycle, then go to WAIT. Clear `wait_cnt` to 0.
- **WAIT:**
  - `enc_start=0`.
  - If `enc_ready=1`, capture `enc_code` into `rsp_code`, set `rsp_err=0`, go to RESP.
  - Otherwise, if `wait_cnt==TIMEOUT-1`, set `rsp_code=0x0000`, `rsp_err=1`, `timeout_sticky=1`, and go to RESP.
  - Otherwise increment `wait_cnt`.
  - `enc_ready` has priority over timeout in the same cycle.
- **RESP:**
  - `rsp_valid=1`. `rsp_id`, `rsp_code` and `rsp_err` are held stable until `rsp_ready=1`.
  - On that handshake, set `rr_ptr = id_q+1`, wrapping N_REQ-1 to 0, and go to IDLE.
- `enc_data` is driven from `msg_q` at all times, so it is stable through START and WAIT.
- `enc_ready` is ignored outside WAIT; the encoder does not clear it on reset.
- Requests that are not granted are not consumed. Requesters must hold `req_valid` and `req_data` until `req_ready`.
- Only one transaction is in flight at a time. There is no request queuing.

## Timing

- **Reset values:** every output is 0. This includes `req_ready`, `enc_start`, `enc_data`, `rsp_valid`, `rsp_id`, `rsp_code`, `rsp_err`, `busy` and `timeout_sticky`. Reset also sets `rr_ptr=0` and `wait_cnt=0`.
- **Nominal latency:**
  - Cycle 0: IDLE accepts the request.
  - Cycle 1: START, `enc_start` high.
  - Cycle 2: WAIT sees `enc_ready` (the encoder is registered).
  - Cycle 3: RESP, `rsp_valid` high.
- **Throughput:** at best one response per 4 cycles when `rsp_ready` is held high.
- **Timeout latency:** `rsp_valid` rises `TIMEOUT+2` cycles after accept.
- `busy` is registered. It is 1 in START, WAIT and RESP.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and all outputs drop asynchronously. The pending message is discarded and no response is issued.
- **Simultaneous requests:** exactly one grant per IDLE cycle. After serving requester k, requester k+1 mod N_REQ has top priority.

## Test plan

- Reset, then requester 0 sends `5'b00001` with `rsp_ready=1`.
  - Expect `req_ready=2'b01` at cycle 0 and `enc_start` one cycle wide at cycle 1.
  - Expect `rsp_valid` at cycle 3 with `rsp_code=0x0537`, `rsp_id=0`, `rsp_err=0`.
- Requester 1 sends `5'b00011`; requester 0 sends `5'b00000`. Check the codeword values:
  - For `5'b00011`, expect `rsp_code=0x0F59`, `rsp_id=1`.
  - For `5'b00000`, expect `rsp_code=0x0000`, `rsp_id=0`.
- Round-robin fairness: both requesters hold `req_valid` continuously for 6 grants. Expect grant order 0,1,0,1,0,1 with no starvation.
- Backpressure: hold `rsp_ready=0` for 10 cycles in RESP.
  - `rsp_*` stays stable and `req_ready` stays 0.
  - On release, there is exactly one handshake, then IDLE.
- Timeout: replace the encoder with a stub that never asserts `enc_ready`, with `TIMEOUT=15`.
  - Expect `rsp_valid` 17 cycles after accept with `rsp_err=1`, `rsp_code=0x0000` and `timeout_sticky=1`.
  - `timeout_sticky` stays set through the next good transaction.
- Assert `rst` during WAIT. Expect all outputs 0 asynchronously, no response, and `rr_ptr=0` afterwards, so requester 0 is granted first.
